// File: rtl/reg16_load_arbiter.sv
// Round-robin arbiter sharing the load port of a single Reg16 register.
// Each grant runs IDLE -> LOAD (reg_ld pulse) -> ACK (one-hot ack pulse) -> IDLE.
module reg16_load_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       reg_ld_o,
    output logic [WIDTH-1:0]           reg_in_o,
    output logic [IDX_W-1:0]           owner_o,
    output logic                       busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     owner_q;
    logic [WIDTH-1:0]     reg_in_q;
    logic                 reg_ld_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 busy_q;

    logic                 found_d;
    logic [IDX_W-1:0]     win_d;
    logic [IDX_W-1:0]     cand_d;
    logic [WIDTH-1:0]     win_data_d;

    // Index base+off wrapped into 0..NUM_REQ-1; works for non-power-of-two NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Search starts at ptr so the last owner has lowest priority next time.
    always_comb begin
        found_d    = 1'b0;
        win_d      = '0;
        cand_d     = '0;
        win_data_d = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_d = rr_idx(ptr_q, off);
            if (!found_d && req_i[cand_d]) begin
                found_d = 1'b1;
                win_d   = cand_d;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_d == IDX_W'(i)) begin
                win_data_d = wdata_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            reg_in_q <= '0;
            reg_ld_q <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    reg_ld_q <= 1'b0;
                    ack_q    <= '0;
                    if (found_d) begin
                        reg_in_q <= win_data_d;
                        owner_q  <= win_d;
                        reg_ld_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    reg_ld_q <= 1'b0;
                    ack_q    <= onehot(owner_q);
                    state_q  <= ACK;
                end
                ACK: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= rr_idx(owner_q, 1);
                    state_q <= IDLE;
                end
                default: begin
                    reg_ld_q <= 1'b0;
                    ack_q    <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ack_o    = ack_q;
    assign reg_ld_o = reg_ld_q;
    assign reg_in_o = reg_in_q;
    assign owner_o  = owner_q;
    assign busy_o   = busy_q;

    a_ld_ack_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(reg_ld_q && (|ack_q)));
    a_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(ack_q));

endmodule

// File: tb/tb_reg16_load_arbiter.sv
// Directed bench for reg16_load_arbiter with a behavioural Reg16 on its load port.
module tb_reg16_load_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic        reg_ld;
    logic [15:0] reg_in;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] r16;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    reg16_load_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .wdata_i  (wdata),
        .ack_o    (ack),
        .reg_ld_o (reg_ld),
        .reg_in_o (reg_in),
        .owner_o  (owner),
        .busy_o   (busy)
    );

    // Reg16 has no reset and loads whenever ld is high.
    always @(posedge clk) begin
        if (reg_ld) r16 <= reg_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ld, input logic [15:0] din,
                           input logic [3:0] a, input logic [1:0] own, input logic b);
        check({tag, "_ld"},    32'(reg_ld), 32'(ld));
        check({tag, "_in"},    32'(reg_in), 32'(din));
        check({tag, "_ack"},   32'(ack),    32'(a));
        check({tag, "_owner"}, 32'(owner),  32'(own));
        check({tag, "_busy"},  32'(busy),   32'(b));
    endtask

    task automatic set_w(input logic [1:0] i, input logic [15:0] v);
        wdata[i*16 +: 16] = v;
    endtask

    // One full grant of requester `who` carrying `d`; requester drops req during its ack.
    task automatic serve(input string tag, input logic [1:0] who, input logic [15:0] d);
        tick();
        chk_out({tag, "_load"}, 1'b1, d, 4'b0000, who, 1'b1);
        tick();
        chk_out({tag, "_ackc"}, 1'b0, d, 4'b0001 << who, who, 1'b1);
        check({tag, "_r16"}, 32'(r16), 32'(d));
        req[who] = 1'b0;
        tick();
        chk_out({tag, "_idle"}, 1'b0, d, 4'b0000, who, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Reset held two cycles with every request raised
        tick();
        chk_out("rst_a", 1'b0, 16'h0000, 4'b0000, 2'd0, 1'b0);
        tick();
        chk_out("rst_b", 1'b0, 16'h0000, 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        serve("first", 2'd0, 16'h1111);

        // Single load, ptr=1 so search wraps to 0
        req = 4'b0001;
        set_w(2'd0, 16'hA5A5);
        serve("single", 2'd0, 16'hA5A5);

        // Round-robin from ptr=0
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        chk_out("rst_c", 1'b0, 16'h0000, 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1111;
        wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        serve("rr0", 2'd0, 16'h1111);
        serve("rr1", 2'd1, 16'h2222);
        serve("rr2", 2'd2, 16'h3333);
        serve("rr3", 2'd3, 16'h4444);

        // Pointer wrap: ptr=3 with 0101, then ptr=1 with 1010
        req = 4'b0100;
        set_w(2'd2, 16'h5555);
        serve("pre2", 2'd2, 16'h5555);
        req = 4'b0101;
        set_w(2'd0, 16'h6666);
        set_w(2'd2, 16'h7777);
        serve("wrap0", 2'd0, 16'h6666);
        serve("wrap2", 2'd2, 16'h7777);
        req = 4'b0001;
        set_w(2'd0, 16'h8888);
        serve("pre0", 2'd0, 16'h8888);
        req = 4'b1010;
        set_w(2'd1, 16'h9999);
        set_w(2'd3, 16'hAAAA);
        serve("wrap1", 2'd1, 16'h9999);
        serve("wrap3", 2'd3, 16'hAAAA);

        // Data freeze: wdata changes during LOAD are ignored
        req = 4'b0010;
        set_w(2'd1, 16'h00FF);
        tick();
        chk_out("frz_load", 1'b1, 16'h00FF, 4'b0000, 2'd1, 1'b1);
        set_w(2'd1, 16'hFF00);
        tick();
        chk_out("frz_ack", 1'b0, 16'h00FF, 4'b0010, 2'd1, 1'b1);
        check("frz_r16a", 32'(r16), 32'h00FF);
        req = 4'b0000;
        tick();
        chk_out("frz_idle", 1'b0, 16'h00FF, 4'b0000, 2'd1, 1'b0);
        check("frz_r16b", 32'(r16), 32'h00FF);
        tick();
        chk_out("frz_idle2", 1'b0, 16'h00FF, 4'b0000, 2'd1, 1'b0);

        // Reset sampled in LOAD: Reg16 still captures, no ack, ptr back to 0
        req = 4'b1000;
        set_w(2'd3, 16'hBEEF);
        tick();
        chk_out("rl_load", 1'b1, 16'hBEEF, 4'b0000, 2'd3, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_out("rl_rst", 1'b0, 16'h0000, 4'b0000, 2'd0, 1'b0);
        check("rl_r16", 32'(r16), 32'hBEEF);
        rst_n = 1'b1;
        req   = 4'b1010;
        set_w(2'd1, 16'h0A0A);
        set_w(2'd3, 16'hC0DE);
        serve("rl_g1", 2'd1, 16'h0A0A);
        serve("rl_g3", 2'd3, 16'hC0DE);

        // Reset sampled in ACK: ack already shown, ptr returns to 0 not owner+1
        req = 4'b0010;
        set_w(2'd1, 16'h1234);
        tick();
        chk_out("ra_load", 1'b1, 16'h1234, 4'b0000, 2'd1, 1'b1);
        tick();
        chk_out("ra_ack", 1'b0, 16'h1234, 4'b0010, 2'd1, 1'b1);
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        chk_out("ra_rst", 1'b0, 16'h0000, 4'b0000, 2'd0, 1'b0);
        check("ra_r16", 32'(r16), 32'h1234);
        rst_n = 1'b1;
        req   = 4'b0110;
        set_w(2'd1, 16'h5678);
        set_w(2'd2, 16'h9ABC);
        serve("ra_g1", 2'd1, 16'h5678);
        serve("ra_g2", 2'd2, 16'h9ABC);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
